// File: rtl/disk_pkg.sv
// Shared state type, beat-count constants and parameter defaults for the disk DMA read controller.
package disk_pkg;

  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_SIZE_W   = 12;
  localparam int DEF_DISK_W   = 32768;
  localparam int DEF_BEAT_W   = 64;
  localparam int DEF_DISK_LAT = 4;

  localparam int MAX_BEATS  = DEF_DISK_W / DEF_BEAT_W;
  localparam int BEAT_IDX_W = $clog2(MAX_BEATS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_STREAM
  } dma_state_e;

endpackage

// File: rtl/disk_beat_mux.sv
// Selects one BEAT_W-wide beat out of the wide disk read word; purely combinational.
module disk_beat_mux #(
  parameter int DISK_W = 32768,
  parameter int BEAT_W = 64,
  parameter int IDX_W  = 9
) (
  input  logic [DISK_W-1:0] disk_data,
  input  logic [IDX_W-1:0]  beat,
  output logic [BEAT_W-1:0] beat_data
);

  assign beat_data = disk_data[32'(beat) * BEAT_W +: BEAT_W];

endmodule

// File: rtl/disk_dma_ctrl.sv
// Disk read DMA: one wide disk read per request, streamed out as BEAT_W beats.
// Optional DISK_DMA_CTRL_BOUNDS_EN rejects oversize / out-of-range requests and flags err.
//
// state     | meaning
// ST_IDLE   | ready for a request
// ST_ISSUE  | disk read issued (or dropped request retired)
// ST_WAIT   | counting down the disk read latency
// ST_STREAM | emitting beats to the memory side
module disk_dma_ctrl
  import disk_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int SIZE_W   = DEF_SIZE_W,
  parameter int DISK_W   = DEF_DISK_W,
  parameter int BEAT_W   = DEF_BEAT_W,
  parameter int DISK_LAT = DEF_DISK_LAT
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [SIZE_W-1:0] req_size,
  output logic              disk_en,
  output logic              disk_we,
  output logic [ADDR_W-1:0] disk_addr,
  output logic [SIZE_W-1:0] disk_size,
  input  logic [DISK_W-1:0] disk_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BEAT_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              err
);

  localparam int NUM_BEATS = DISK_W / BEAT_W;
  localparam int IDX_W     = $clog2(NUM_BEATS);
  localparam logic [SIZE_W-1:0] SIZE_MAX = SIZE_W'(NUM_BEATS);
  localparam logic [3:0]        LAT_M1   = 4'(DISK_LAT - 1);

  dma_state_e        state_q, state_d;
  logic [3:0]        wait_cnt_q;
  logic [IDX_W-1:0]  beat_q;
  logic [ADDR_W-1:0] addr_q;
  logic [SIZE_W-1:0] size_q;
  logic              drop_q, init_q;
  logic              accept, beat_done, bad_req;
  logic [SIZE_W-1:0] size_in;

  assign accept    = req_valid && req_ready;
  assign beat_done = (state_q == ST_STREAM) && out_ready;
  assign out_last  = (state_q == ST_STREAM) && (SIZE_W'(beat_q) == size_q - 1'b1);
  assign disk_we   = 1'b0;
  assign disk_addr = addr_q;
  assign disk_size = size_q;

`ifdef DISK_DMA_CTRL_BOUNDS_EN
  logic err_q;
  assign bad_req = (req_size > SIZE_MAX) || (req_addr[ADDR_W-1:29] != '0);
  assign size_in = req_size;
  assign err     = err_q;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) err_q <= 1'b0;
    else if (accept && bad_req) err_q <= 1'b1;
  end
`else
  assign bad_req = 1'b0;
  assign size_in = (req_size > SIZE_MAX) ? SIZE_MAX : req_size;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    busy      = (state_q != ST_IDLE);
    disk_en   = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = init_q;
        if (accept) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        disk_en = !drop_q;
        state_d = drop_q ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        disk_en = 1'b1;
        if (wait_cnt_q == 4'd0) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        disk_en   = 1'b1;
        out_valid = 1'b1;
        if (beat_done && out_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // init_q holds off req_ready until the first clock after reset release
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      init_q     <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      drop_q     <= 1'b0;
      wait_cnt_q <= '0;
      beat_q     <= '0;
    end else begin
      init_q <= 1'b1;
      if (accept) begin
        addr_q <= req_addr;
        size_q <= size_in;
        drop_q <= bad_req || (size_in == '0);
      end
      if (state_q == ST_ISSUE)                          wait_cnt_q <= LAT_M1;
      else if (state_q == ST_WAIT && wait_cnt_q != 4'd0) wait_cnt_q <= wait_cnt_q - 4'd1;
      if (state_q != ST_STREAM) beat_q <= '0;
      else if (beat_done)       beat_q <= beat_q + 1'b1;
    end
  end

  disk_beat_mux #(
    .DISK_W(DISK_W),
    .BEAT_W(BEAT_W),
    .IDX_W (IDX_W)
  ) u_beat_mux (
    .disk_data(disk_data),
    .beat     (beat_q),
    .beat_data(out_data)
  );

endmodule

// File: tb/tb_disk_dma_ctrl.sv
// Self-checking bench for disk_dma_ctrl: transaction-level reference model plus directed cover cases.
`timescale 1ns/1ps
module tb_disk_dma_ctrl;

  localparam int DISK_W   = 32768;
  localparam int BEAT_W   = 64;
  localparam int DISK_LAT = 4;
  localparam int NB       = DISK_W / BEAT_W;

  logic              clk = 1'b0;
  logic              RST = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [31:0]       req_addr = '0;
  logic [11:0]       req_size = '0;
  logic              disk_en, disk_we;
  logic [31:0]       disk_addr;
  logic [11:0]       disk_size;
  logic [DISK_W-1:0] disk_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [63:0]       out_data;
  logic              out_last, busy, err;

  disk_dma_ctrl #(
    .ADDR_W(32), .SIZE_W(12), .DISK_W(DISK_W), .BEAT_W(BEAT_W), .DISK_LAT(DISK_LAT)
  ) dut (
    .clk(clk), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_size(req_size),
    .disk_en(disk_en), .disk_we(disk_we), .disk_addr(disk_addr), .disk_size(disk_size),
    .disk_data(disk_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_checks = 0, n_fail = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] beat_word(input int s, input int k);
    return {32'(s), 32'(k)};
  endfunction

  int seed_cur = 0;
  task automatic set_disk(input int s);
    seed_cur = s;
    for (int k = 0; k < NB; k++) disk_data[k*BEAT_W +: BEAT_W] = beat_word(s, k);
  endtask

  // reference model state
  bit          seen = 1'b0;
  bit          m_active = 1'b0, m_drop = 1'b0, m_err = 1'b0;
  int          m_t = 0;
  logic [31:0] m_addr;
  logic [11:0] m_size;
  logic [63:0] m_q[$];
  int          acc_cnt = 0, acc_cyc = 0;
  int          d, sz;
  bit          bad, busy_e, en_e, ov_e, rdy_e;
  // observation logs for directed cases
  logic [63:0] beat_log[$];
  int          hs_log[$];
  int          busy_cnt = 0, en_cnt = 0, ov_cnt = 0, fv_cyc = -1;
  int          ready_mode = 0;
  logic [3:0]  patt = 4'b1001;

  always @(posedge clk or negedge RST) begin
    if (!RST) seen <= 1'b0;
    else      seen <= 1'b1;
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = patt[cyc % 4];
    endcase
  end

  always @(negedge clk) begin
    if (!RST) begin
      check("rst_busy", busy, 0);
      check("rst_disk_en", disk_en, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_err", err, 0);
      m_active = 1'b0;
      m_err    = 1'b0;
      m_q.delete();
    end else begin
      d      = cyc - m_t;
      busy_e = m_active;
      en_e   = m_active && !m_drop;
      ov_e   = en_e && (d >= 2 + DISK_LAT) && (m_q.size() > 0);
      rdy_e  = seen && !m_active;
      check("busy", busy, busy_e);
      check("disk_en", disk_en, en_e);
      check("out_valid", out_valid, ov_e);
      check("req_ready", req_ready, rdy_e);
      check("disk_we", disk_we, 0);
      check("err", err, m_err);
      if (en_e) begin
        check("disk_addr", disk_addr, m_addr);
        check("disk_size", disk_size, m_size);
      end
      if (ov_e) begin
        check("out_data", out_data, m_q[0]);
        check("out_last", out_last, m_q.size() == 1);
      end
      if (busy) busy_cnt++;
      if (disk_en) en_cnt++;
      if (out_valid) begin
        ov_cnt++;
        if (fv_cyc < 0) fv_cyc = cyc;
      end
      if (m_active && m_drop) m_active = 1'b0;
      else if (ov_e && out_ready) begin
        beat_log.push_back(out_data);
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_active = 1'b0;
          hs_log.push_back(cyc);
        end
      end
      if (rdy_e && req_valid) begin
        m_active = 1'b1;
        m_t      = cyc;
        acc_cyc  = cyc;
        acc_cnt++;
        sz  = int'(req_size);
        bad = 1'b0;
`ifdef DISK_DMA_CTRL_BOUNDS_EN
        bad = (sz > NB) || (req_addr[31:29] != 3'b000);
        if (bad) m_err = 1'b1;
`else
        if (sz > NB) sz = NB;
`endif
        m_drop = bad || (sz == 0);
        m_addr = req_addr;
        m_size = 12'(sz);
        m_q.delete();
        if (!m_drop) for (int k = 0; k < sz; k++) m_q.push_back(beat_word(seed_cur, k));
      end
    end
  end

  task automatic clear_log();
    beat_log.delete();
    hs_log.delete();
    busy_cnt = 0; en_cnt = 0; ov_cnt = 0; fv_cyc = -1;
  endtask

  // called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic do_req(input logic [31:0] a, input logic [11:0] s, input bit hold);
    int start, i;
    start = acc_cnt;
    req_valid = 1'b1;
    req_addr  = a;
    req_size  = s;
    i = 0;
    while (acc_cnt == start && i < 300) begin
      @(posedge clk);
      i++;
    end
    #1;
    if (!hold) req_valid = 1'b0;
    check("accept_timeout", acc_cnt != start, 1);
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (m_active && i < 6000) begin
      @(posedge clk);
      i++;
    end
    #1;
    check("idle_timeout", m_active, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1);
  end

  initial begin
    int a1, i;
    logic [31:0] ra;
    logic [11:0] rs;
    int r;
    set_disk(0);
    repeat (3) @(posedge clk);
    #2 RST = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", req_ready, 1);

    // incrementing words, 4 beats, first valid at T+6
    clear_log(); set_disk(0); ready_mode = 0;
    do_req(32'h1FFF_FFFE, 12'd4, 0);
    wait_idle();
    check("c028_latency", fv_cyc - acc_cyc, 6);
    check("c028_beats", beat_log.size(), 4);
    for (int k = 0; k < 4 && k < beat_log.size(); k++) check("c028_data", beat_log[k], 64'(k));
    check("c028_en_cycles", en_cnt, 9);
    check("c028_en_after", disk_en, 0);

    // backpressure 1,0,0,1
    clear_log(); set_disk(7); ready_mode = 2;
    do_req(32'h0000_1000, 12'd3, 0);
    wait_idle();
    check("c029_beats", beat_log.size(), 3);
    for (int k = 0; k < 3 && k < beat_log.size(); k++) check("c029_data", beat_log[k], {32'd7, 32'(k)});

    // size zero
    clear_log(); ready_mode = 0;
    do_req(32'h0000_2000, 12'd0, 0);
    wait_idle();
    repeat (2) @(posedge clk); #1;
    check("c030_busy_cycles", busy_cnt, 1);
    check("c030_en_cycles", en_cnt, 0);
    check("c030_valid_cycles", ov_cnt, 0);

    // oversize / out-of-range
    clear_log(); set_disk(5); ready_mode = 1;
    do_req(32'h0000_0100, 12'd600, 0);
    wait_idle();
`ifdef DISK_DMA_CTRL_BOUNDS_EN
    do_req(32'h2000_0000, 12'd4, 0);
    wait_idle();
    check("c031_err", err, 1);
    check("c031_en_cycles", en_cnt, 0);
    check("c031_beats", beat_log.size(), 0);
`else
    check("c031_beats", beat_log.size(), 512);
    if (beat_log.size() == 512) check("c031_last_word", beat_log[511], {32'd5, 32'd511});
    check("c031_err", err, 0);
`endif

    // reset during beat 2 of 8
    clear_log(); set_disk(3); ready_mode = 0;
    do_req(32'h0000_0040, 12'd8, 0);
    i = 0;
    while (beat_log.size() < 2 && i < 100) begin
      @(posedge clk);
      i++;
    end
    #2 RST = 1'b0;
    #1;
    check("c032_valid_on_reset", out_valid, 0);
    check("c032_busy_on_reset", busy, 0);
    check("c032_ready_on_reset", req_ready, 0);
    repeat (2) @(negedge clk);
    #2 RST = 1'b1;
    @(posedge clk); #1;
    check("c032_ready_after", req_ready, 1);
    check("c032_beats_before", beat_log.size(), 2);
    clear_log();
    do_req(32'h0000_0080, 12'd8, 0);
    wait_idle();
    check("c032_next_beats", beat_log.size(), 8);
    if (beat_log.size() == 8) check("c032_next_last", beat_log[7], {32'd3, 32'd7});

    // back-to-back with req_valid held
    clear_log(); set_disk(9); ready_mode = 1;
    do_req(32'h0000_0300, 12'd5, 1);
    a1 = acc_cyc;
    do_req(32'h0000_0400, 12'd2, 0);
    wait_idle();
    check("c033_hs_count", hs_log.size(), 2);
    if (hs_log.size() > 0) check("c033_gap", acc_cyc - hs_log[0], 1);
    check("c033_first_beats", hs_log.size() > 0 && hs_log[0] > a1, 1);
    check("c033_beats", beat_log.size(), 7);

    // randomized traffic
    for (int it = 0; it < 25; it++) begin
      set_disk(int'($urandom));
      ready_mode = $urandom_range(0, 2);
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra[31:29] = 3'b000;
      r = $urandom_range(0, 9);
      if (r == 0)      rs = 12'd0;
      else if (r == 1) rs = 12'($urandom_range(500, 700));
      else             rs = 12'($urandom_range(1, 40));
      do_req(ra, rs, 0);
      wait_idle();
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
